selecting_machine_n: RTL and testbench



---
 rtl/sel_pkg.sv | 31 +++
 rtl/sel_debounce.sv | 69 ++++++
 rtl/selecting_machine_n.sv | 108 ++++++++++
 tb/tb_selecting_machine_n.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sel_pkg.sv
// Shared mode encoding and bit-vector helpers for the selecting machine.
// Helpers operate on a 16-bit view; callers zero-extend narrower vectors.
package sel_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_EXCL   = 2'b01,
    MODE_LIMIT  = 2'b10,
    MODE_HOLD   = 2'b11
  } sel_mode_e;

  localparam int SEL_MAX_CH = 16;

  function automatic logic [4:0] sel_popcount(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < SEL_MAX_CH; i++) c = c + {4'b0000, v[i]};
    return c;
  endfunction

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [3:0] sel_lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = SEL_MAX_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sel_debounce.sv
// One button channel: 2-FF synchroniser, stability counter and press pulse.
// LONG_PRESS_CLR_EN adds a saturating hold counter that pulses long_hit once per hold.
module sel_debounce import sel_pkg::*; #(
  parameter int DB_CYCLES = 20000,
  parameter int LP_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press,
  output logic long_hit
);

  localparam int DB_W = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == DB_LAST) stable_d = sync2_q;
      else                  cnt_d    = cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Only the accepted 1->0 edge is a press; release is silent.
  assign press = stable_q & ~stable_d;

`ifdef LONG_PRESS_CLR_EN
  localparam int LP_W = $clog2(LP_CYCLES + 1);
  localparam logic [LP_W-1:0] LP_MAX = LP_W'(LP_CYCLES);

  logic [LP_W-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = '0;
    if (!stable_q) hold_d = (hold_q == LP_MAX) ? hold_q : hold_q + LP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end

  assign long_hit = !stable_q && (hold_q == LP_MAX - LP_W'(1));
`else
  // Long press disabled: a held button behaves exactly like a short press.
  assign long_hit = (LP_CYCLES < 0);
`endif

endmodule

// File: rtl/selecting_machine_n.sv
// N-channel debounced button selector with toggle / exclusive / limited / hold modes.
// Optional LONG_PRESS_CLR_EN: holding any button past LP_CYCLES clears the selection.
module selecting_machine_n import sel_pkg::*; #(
  parameter int             N         = 8,
  parameter int             DB_CYCLES = 20000,
  parameter int             MAX_SEL   = 3,
  parameter logic [N-1:0]   RESET_SEL = {N{1'b1}},
  parameter int             LP_CYCLES = 2000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N-1:0]             btn_n,
  input  logic [1:0]               mode,
  input  logic                     lock,
  output logic [N-1:0]             sel,
  output logic [$clog2(N+1)-1:0]   sel_cnt,
  output logic                     sel_chg,
  output logic                     reject
);

  localparam int CW = $clog2(N + 1);
  localparam logic [15:0]   RESET16   = 16'(RESET_SEL);
  localparam logic [CW-1:0] RESET_CNT = CW'(sel_popcount(RESET16));
  localparam logic [CW-1:0] MAX_C     = CW'(MAX_SEL);

  logic [N-1:0] press, long_hit;

  for (genvar i = 0; i < N; i++) begin : g_ch
    sel_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .LP_CYCLES(LP_CYCLES)
    ) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_n    (btn_n[i]),
      .press    (press[i]),
      .long_hit (long_hit[i])
    );
  end

  logic [N-1:0]  sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          chg_q, chg_d;
  logic          reject_q, reject_d;

  logic [N-1:0]  press_v, first;
  logic [15:0]   p16, s16;
  logic [3:0]    first_idx;
  logic          extra;

  always_comb begin
    press_v   = lock ? '0 : press;
    p16       = '0;
    p16[N-1:0] = press_v;
    first_idx = sel_lowest_idx(p16);
    first     = N'(1) << first_idx;
    extra     = |(press_v & ~first);
    sel_d     = sel_q;
    reject_d  = 1'b0;

    case (sel_mode_e'(mode))
      MODE_TOGGLE: sel_d = sel_q ^ press_v;
      MODE_EXCL: begin
        if (|press_v) begin
          sel_d    = first;
          reject_d = extra;
        end
      end
      MODE_LIMIT: begin
        // Deselect is always allowed, so an over-full set can still shrink.
        if (|press_v) begin
          reject_d = extra;
          if (|(sel_q & first))  sel_d    = sel_q & ~first;
          else if (cnt_q < MAX_C) sel_d   = sel_q | first;
          else                   reject_d = 1'b1;
        end
      end
      default: reject_d = |press_v;
    endcase

    if (!lock && |long_hit) sel_d = '0;

    s16        = '0;
    s16[N-1:0] = sel_d;
    cnt_d      = CW'(sel_popcount(s16));
    chg_d      = (sel_d != sel_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q    <= RESET_SEL;
      cnt_q    <= RESET_CNT;
      chg_q    <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      chg_q    <= chg_d;
      reject_q <= reject_d;
    end
  end

  assign sel     = sel_q;
  assign sel_cnt = cnt_q;
  assign sel_chg = chg_q;
  assign reject  = reject_q;

endmodule

// File: tb/tb_selecting_machine_n.sv
// Directed bench for selecting_machine_n (N=4, DB_CYCLES=4, MAX_SEL=2, LP_CYCLES=50).
// Expected long-press behaviour follows LONG_PRESS_CLR_EN.
module tb_selecting_machine_n;

  localparam int N         = 4;
  localparam int DB_CYCLES = 4;
  localparam int MAX_SEL   = 2;
  localparam int LP_CYCLES = 50;
  // 2 synchroniser edges + DB_CYCLES counting edges before sel updates.
  localparam int PRESS_LAT = 2 + DB_CYCLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_n = '1;
  logic [1:0]   mode = 2'b00;
  logic         lock = 1'b0;
  logic [N-1:0] sel;
  logic [2:0]   sel_cnt;
  logic         sel_chg;
  logic         reject;

  int tests_run    = 0;
  int tests_failed = 0;

  selecting_machine_n #(
    .N(N), .DB_CYCLES(DB_CYCLES), .MAX_SEL(MAX_SEL),
    .RESET_SEL(4'b1111), .LP_CYCLES(LP_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .mode(mode), .lock(lock),
    .sel(sel), .sel_cnt(sel_cnt), .sel_chg(sel_chg), .reject(reject)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the masked buttons low for 'hold' cycles, release, let them settle.
  task automatic push(input logic [N-1:0] mask, input int hold,
                      output logic [N-1:0] sel_pre, output logic [N-1:0] sel_at,
                      output int chg_n, output int rej_n);
    chg_n   = 0;
    rej_n   = 0;
    sel_pre = sel;
    sel_at  = sel;
    btn_n   = btn_n & ~mask;
    for (int c = 1; c <= hold; c++) begin
      tick();
      if (sel_chg) chg_n++;
      if (reject)  rej_n++;
      if (c == PRESS_LAT - 1) sel_pre = sel;
      if (c == PRESS_LAT)     sel_at  = sel;
    end
    btn_n = btn_n | mask;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (sel_chg) chg_n++;
      if (reject)  rej_n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    tests_run++; if (sel !== 4'b1111) begin tests_failed++; $display("FAIL reset_sel: got %b want 1111", sel); end
    tests_run++; if (sel_cnt !== 3'd4) begin tests_failed++; $display("FAIL reset_cnt: got %0d want 4", sel_cnt); end
    tests_run++; if (sel_chg !== 1'b0) begin tests_failed++; $display("FAIL reset_chg: got %b want 0", sel_chg); end
    tests_run++; if (reject !== 1'b0) begin tests_failed++; $display("FAIL reset_reject: got %b want 0", reject); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_toggle();
    logic [N-1:0] pre, at;
    int chg_n, rej_n;
    mode = 2'b00;
    push(4'b0010, 10, pre, at, chg_n, rej_n);
    tests_run++; if (pre !== 4'b1111) begin tests_failed++; $display("FAIL toggle_latency_early: got %b want 1111", pre); end
    tests_run++; if (at !== 4'b1101) begin tests_failed++; $display("FAIL toggle_sel: got %b want 1101", at); end
    tests_run++; if (sel_cnt !== 3'd3) begin tests_failed++; $display("FAIL toggle_cnt: got %0d want 3", sel_cnt); end
    tests_run++; if (chg_n != 1) begin tests_failed++; $display("FAIL toggle_chg_pulses: got %0d want 1", chg_n); end
    tests_run++; if (rej_n != 0) begin tests_failed++; $display("FAIL toggle_reject: got %0d want 0", rej_n); end
    push(4'b0100, 2, pre, at, chg_n, rej_n);
    tests_run++; if (sel !== 4'b1101) begin tests_failed++; $display("FAIL glitch_sel: got %b want 1101", sel); end
    tests_run++; if (chg_n != 0) begin tests_failed++; $display("FAIL glitch_chg: got %0d want 0", chg_n); end
  endtask

  task automatic test_exclusive();
    logic [N-1:0] pre, at;
    int chg_n, rej_n;
    mode = 2'b01;
    push(4'b0100, 10, pre, at, chg_n, rej_n);
    tests_run++; if (at !== 4'b0100) begin tests_failed++; $display("FAIL excl_sel: got %b want 0100", at); end
    tests_run++; if (chg_n != 1 || rej_n != 0) begin tests_failed++; $display("FAIL excl_pulses: chg %0d rej %0d want 1 0", chg_n, rej_n); end
    push(4'b0100, 10, pre, at, chg_n, rej_n);
    tests_run++; if (sel !== 4'b0100) begin tests_failed++; $display("FAIL excl_same_sel: got %b want 0100", sel); end
    tests_run++; if (chg_n != 0 || rej_n != 0) begin tests_failed++; $display("FAIL excl_same_pulses: chg %0d rej %0d want 0 0", chg_n, rej_n); end
    push(4'b1001, 10, pre, at, chg_n, rej_n);
    tests_run++; if (at !== 4'b0001) begin tests_failed++; $display("FAIL excl_multi_sel: got %b want 0001", at); end
    tests_run++; if (chg_n != 1 || rej_n != 1) begin tests_failed++; $display("FAIL excl_multi_pulses: chg %0d rej %0d want 1 1", chg_n, rej_n); end
    tests_run++; if (sel_cnt !== 3'd1) begin tests_failed++; $display("FAIL excl_multi_cnt: got %0d want 1", sel_cnt); end
  endtask

  task automatic test_limited();
    logic [N-1:0] pre, at;
    int chg_n, rej_n;
    mode = 2'b00;
    push(4'b0010, 10, pre, at, chg_n, rej_n);
    tests_run++; if (sel !== 4'b0011) begin tests_failed++; $display("FAIL limit_setup: got %b want 0011", sel); end
    mode = 2'b10;
    push(4'b1000, 10, pre, at, chg_n, rej_n);
    tests_run++; if (sel !== 4'b0011) begin tests_failed++; $display("FAIL limit_full_sel: got %b want 0011", sel); end
    tests_run++; if (chg_n != 0 || rej_n != 1) begin tests_failed++; $display("FAIL limit_full_pulses: chg %0d rej %0d want 0 1", chg_n, rej_n); end
    push(4'b0001, 10, pre, at, chg_n, rej_n);
    tests_run++; if (sel !== 4'b0010 || sel_cnt !== 3'd1) begin tests_failed++; $display("FAIL limit_deselect: got %b/%0d want 0010/1", sel, sel_cnt); end
    push(4'b1000, 10, pre, at, chg_n, rej_n);
    tests_run++; if (sel !== 4'b1010 || sel_cnt !== 3'd2) begin tests_failed++; $display("FAIL limit_select: got %b/%0d want 1010/2", sel, sel_cnt); end
    tests_run++; if (rej_n != 0) begin tests_failed++; $display("FAIL limit_select_reject: got %0d want 0", rej_n); end
    push(4'b0110, 10, pre, at, chg_n, rej_n);
    tests_run++; if (sel !== 4'b1000) begin tests_failed++; $display("FAIL limit_multi_sel: got %b want 1000", sel); end
    tests_run++; if (chg_n != 1 || rej_n != 1) begin tests_failed++; $display("FAIL limit_multi_pulses: chg %0d rej %0d want 1 1", chg_n, rej_n); end
  endtask

  task automatic test_lock_hold();
    logic [N-1:0] pre, at;
    int chg_n, rej_n;
    mode = 2'b00;
    lock = 1'b1;
    push(4'b0010, 10, pre, at, chg_n, rej_n);
    tests_run++; if (sel !== 4'b1000) begin tests_failed++; $display("FAIL lock_sel: got %b want 1000", sel); end
    tests_run++; if (chg_n != 0 || rej_n != 0) begin tests_failed++; $display("FAIL lock_pulses: chg %0d rej %0d want 0 0", chg_n, rej_n); end
    lock = 1'b0;
    mode = 2'b11;
    push(4'b0010, 10, pre, at, chg_n, rej_n);
    tests_run++; if (sel !== 4'b1000) begin tests_failed++; $display("FAIL hold_sel: got %b want 1000", sel); end
    tests_run++; if (chg_n != 0 || rej_n != 1) begin tests_failed++; $display("FAIL hold_pulses: chg %0d rej %0d want 0 1", chg_n, rej_n); end
  endtask

  task automatic test_reset_mid();
    mode = 2'b00;
    btn_n[0] = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    rst_n = 1'b0;
    tick();
    tests_run++; if (sel !== 4'b1111 || sel_cnt !== 3'd4) begin tests_failed++; $display("FAIL midreset_sel: got %b/%0d want 1111/4", sel, sel_cnt); end
    rst_n = 1'b1;
    for (int c = 1; c <= PRESS_LAT; c++) begin
      tick();
      if (c == PRESS_LAT - 1) begin
        tests_run++; if (sel !== 4'b1111) begin tests_failed++; $display("FAIL midreset_early: got %b want 1111", sel); end
      end
    end
    tests_run++; if (sel !== 4'b1110 || sel_chg !== 1'b1) begin tests_failed++; $display("FAIL midreset_press: got %b chg %b want 1110 chg 1", sel, sel_chg); end
    btn_n[0] = 1'b1;
    for (int c = 0; c < 10; c++) tick();
  endtask

  task automatic test_long_press();
    logic [N-1:0] pre, at;
    int chg_n, rej_n;
    mode = 2'b00;
    push(4'b0010, 60, pre, at, chg_n, rej_n);
    tests_run++; if (at !== 4'b1100) begin tests_failed++; $display("FAIL long_initial_toggle: got %b want 1100", at); end
`ifdef LONG_PRESS_CLR_EN
    tests_run++; if (chg_n != 2) begin tests_failed++; $display("FAIL long_chg_pulses: got %0d want 2", chg_n); end
    tests_run++; if (sel !== 4'b0000 || sel_cnt !== 3'd0) begin tests_failed++; $display("FAIL long_clear: got %b/%0d want 0000/0", sel, sel_cnt); end
`else
    tests_run++; if (chg_n != 1) begin tests_failed++; $display("FAIL long_chg_pulses: got %0d want 1", chg_n); end
    tests_run++; if (sel !== 4'b1100 || sel_cnt !== 3'd2) begin tests_failed++; $display("FAIL long_no_clear: got %b/%0d want 1100/2", sel, sel_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_exclusive();
    test_limited();
    test_lock_hold();
    test_reset_mid();
    test_long_press();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
